pll_lock_sequencer: RTL

//   Reset/lock sequencer for a board PLL instance (altera_pll wrapper: rst in, locked out).
//   - Holds the PLL in reset at start-up.
//   - Waits for lock, then filters lock for stability before releasing the downstream system reset.
//   - Re-sequences the PLL on loss of lock, on lock timeout, or on a software request.
//   - Runs on the free-running reference clock, so it never depends on PLL outputs.

---
 rtl/pll_lock_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for a board PLL: holds the PLL in reset, waits for and filters lock,
// then releases the downstream reset; re-sequences on lock loss, timeout or software request.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 10000,
  parameter int unsigned FILT_CYCLES  = 64,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             reseq_req,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             pll_ok,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int unsigned MaxRf     = (RST_CYCLES > FILT_CYCLES) ? RST_CYCLES : FILT_CYCLES;
  localparam int unsigned MaxCycles = (LOCK_TIMEOUT > MaxRf) ? LOCK_TIMEOUT : MaxRf;
  localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [TimerW-1:0] RstLast  = TimerW'(RST_CYCLES - 1);
  localparam logic [TimerW-1:0] TmoLast  = TimerW'(LOCK_TIMEOUT - 1);
  localparam logic [TimerW-1:0] FiltLast = TimerW'(FILT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CntMax   = '1;

  typedef enum logic [1:0] {
    StRstPll   = 2'd0,
    StWaitLock = 2'd1,
    StFilter   = 2'd2,
    StRun      = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              sync1_q, locked_s_q;
  logic              loss_hit, tmo_hit;

  // pll_locked is asynchronous to refclk; locked_s_q is the only version the FSM looks at.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 1'b1;
    loss_hit = 1'b0;
    tmo_hit  = 1'b0;

    unique case (state_q)
      StRstPll: begin
        if (timer_q == RstLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (locked_s_q) begin
          state_d = StFilter;
        end else if (timer_q == TmoLast) begin
          state_d = StRstPll;
          tmo_hit = 1'b1;
        end
      end
      StFilter: begin
        if (!locked_s_q) begin
          state_d = StWaitLock;
        end else if (timer_q == FiltLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        timer_d = '0;
        if (!locked_s_q) begin
          state_d  = StRstPll;
          loss_hit = 1'b1;
        end
      end
      default: state_d = StRstPll;
    endcase

    // Software request overrides everything, but event counters still see what happened.
    if (reseq_req && (state_q != StRstPll)) state_d = StRstPll;

    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= StRstPll;
      timer_q     <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      pll_ok      <= 1'b0;
      loss_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      // Outputs decode the next state so they switch on the same edge as state_q.
      pll_rst <= (state_d == StRstPll);
      sys_rst <= (state_d != StRun);
      pll_ok  <= (state_d == StRun);
      if (loss_hit && (loss_cnt != CntMax)) loss_cnt <= loss_cnt + 1'b1;
      if (tmo_hit && (timeout_cnt != CntMax)) timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

  assign state_o = state_q;

endmodule
